// File: rtl/nanosoc_apb_usrt_pkg.sv
// rtl/nanosoc_apb_usrt_pkg.sv - register map and field positions for the APB USRT bridge
//
// Purpose: shared constants for nanosoc_apb_usrt.
// Ports:   none (package).

package nanosoc_apb_usrt_pkg;

    // Word index taken from PADDR[3:2].
    typedef enum logic [1:0] {
        REG_DATA   = 2'd0,   // 0x0
        REG_STATUS = 2'd1,   // 0x4
        REG_CTRL   = 2'd2,   // 0x8
        REG_COUNT  = 2'd3    // 0xC
    } reg_sel_e;

    // STATUS bit indices
    localparam int ST_TXFULL  = 0;
    localparam int ST_TXEMPTY = 1;
    localparam int ST_RXFULL  = 2;
    localparam int ST_RXEMPTY = 3;
    localparam int ST_TXOVF   = 4;
    localparam int ST_RXUNF   = 5;
    localparam int ST_W       = 6;

    // CTRL bit indices
    localparam int CTRL_EN    = 0;
    localparam int CTRL_TXIE  = 1;
    localparam int CTRL_RXIE  = 2;
    localparam int CTRL_FLUSH = 3;

    // COUNT field positions
    localparam int COUNT_TX_LSB = 0;
    localparam int COUNT_RX_LSB = 8;

endpackage

// File: rtl/nanosoc_sync_fifo.sv
// rtl/nanosoc_sync_fifo.sv - 8-bit synchronous FIFO with push/pop/flush and occupancy
//
// Purpose: single-clock byte FIFO. Full/empty come from the registered
//          occupancy, so a push into a full FIFO is rejected even when a pop
//          happens in the same cycle. Flush overrides push and pop.
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   push, push_data  write request and byte
//   pop              read request (advances head)
//   flush            empty the FIFO this cycle
//   head             byte at the read pointer
//   full, empty      registered occupancy flags
//   count            registered occupancy (0..DEPTH)
//   empty_next       occupancy will be zero after this edge

module nanosoc_sync_fifo #(
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic [7:0]    push_data,
    input  logic          pop,
    input  logic          flush,
    output logic [7:0]    head,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   count,
    output logic          empty_next
);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count_d;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign head    = mem[rd_ptr];

    always_comb begin
        count_d = count;
        if (flush) begin
            count_d = '0;
        end else begin
            case ({do_push, do_pop})
                2'b10:   count_d = count + (AW+1)'(1);
                2'b01:   count_d = count - (AW+1)'(1);
                default: count_d = count;
            endcase
        end
    end

    // Lets the parent register flags that depend on the post-edge state.
    assign empty_next = (count_d == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count_d;
        end
    end

endmodule

// File: rtl/nanosoc_apb_usrt.sv
// rtl/nanosoc_apb_usrt.sv - APB slave bridging register accesses to TX/RX byte streams
//
// Purpose: zero-wait-state APB slave with a TX FIFO (APB writes -> TX stream)
//          and an RX FIFO (RX stream -> APB reads), sticky error flags and a
//          registered level interrupt.
// Ports:
//   PCLK, PRESETn                 clock, asynchronous active-low reset
//   PSEL, PENABLE, PWRITE         APB control
//   PADDR, PWDATA                 APB address / write data
//   PRDATA, PREADY, PSLVERR       APB response (PREADY tied high)
//   TX_VALID, TX_DATA, TX_READY   transmit byte stream (out)
//   RX_VALID, RX_DATA, RX_READY   receive byte stream (in)
//   IRQ                           level interrupt, active high

module nanosoc_apb_usrt
    import nanosoc_apb_usrt_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int APB_ADDR_W = 12,
    parameter int APB_DATA_W = 32
) (
    input  logic                  PCLK,
    input  logic                  PRESETn,
    input  logic                  PSEL,
    input  logic                  PENABLE,
    input  logic                  PWRITE,
    input  logic [APB_ADDR_W-1:0] PADDR,
    input  logic [APB_DATA_W-1:0] PWDATA,
    output logic [APB_DATA_W-1:0] PRDATA,
    output logic                  PREADY,
    output logic                  PSLVERR,
    output logic                  TX_VALID,
    output logic [7:0]            TX_DATA,
    input  logic                  TX_READY,
    input  logic                  RX_VALID,
    input  logic [7:0]            RX_DATA,
    output logic                  RX_READY,
    output logic                  IRQ
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic          access, addr_ok, wr_acc, rd_acc;
    reg_sel_e      sel;
    logic          data_wr, data_rd, status_wr, ctrl_wr, flush;
    logic          en, txie, rxie, txovf, rxunf, irq_q;
    logic          en_d, txie_d, rxie_d, txovf_d, rxunf_d, irq_d;
    logic          tx_push, tx_pop, rx_push, rx_pop;
    logic          tx_full, tx_empty, tx_empty_next;
    logic          rx_full, rx_empty, rx_empty_next;
    logic [CW-1:0] tx_count, rx_count;
    logic [7:0]    tx_head, rx_head;
    logic [ST_W-1:0]       status;
    logic [APB_DATA_W-1:0] rdata;
    logic          unused_bits;

    // PADDR[1:0] and the upper write-data bits carry no meaning here.
    assign unused_bits = ^{PADDR[1:0], PWDATA[APB_DATA_W-1:8]};

    // ---------------- APB decode ----------------
    assign access  = PSEL & PENABLE;
    assign addr_ok = (PADDR[APB_ADDR_W-1:4] == '0);
    assign sel     = reg_sel_e'(PADDR[3:2]);
    assign wr_acc  = access &  PWRITE & addr_ok;
    assign rd_acc  = access & ~PWRITE & addr_ok;

    assign data_wr   = wr_acc & (sel == REG_DATA);
    assign data_rd   = rd_acc & (sel == REG_DATA);
    assign status_wr = wr_acc & (sel == REG_STATUS);
    assign ctrl_wr   = wr_acc & (sel == REG_CTRL);
    assign flush     = ctrl_wr & PWDATA[CTRL_FLUSH];

    // ---------------- streams ----------------
    assign TX_VALID = en & ~tx_empty;
    assign TX_DATA  = tx_head;
    assign RX_READY = en & ~rx_full;

    assign tx_push = data_wr;
    assign tx_pop  = TX_VALID & TX_READY;
    assign rx_push = RX_VALID & RX_READY;
    assign rx_pop  = data_rd & ~rx_empty;

    nanosoc_sync_fifo #(.DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk        (PCLK),
        .rst_n      (PRESETn),
        .push       (tx_push),
        .push_data  (PWDATA[7:0]),
        .pop        (tx_pop),
        .flush      (flush),
        .head       (tx_head),
        .full       (tx_full),
        .empty      (tx_empty),
        .count      (tx_count),
        .empty_next (tx_empty_next)
    );

    nanosoc_sync_fifo #(.DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk        (PCLK),
        .rst_n      (PRESETn),
        .push       (rx_push),
        .push_data  (RX_DATA),
        .pop        (rx_pop),
        .flush      (flush),
        .head       (rx_head),
        .full       (rx_full),
        .empty      (rx_empty),
        .count      (rx_count),
        .empty_next (rx_empty_next)
    );

    // ---------------- control / sticky next state ----------------
    always_comb begin
        en_d   = ctrl_wr ? PWDATA[CTRL_EN]   : en;
        txie_d = ctrl_wr ? PWDATA[CTRL_TXIE] : txie;
        rxie_d = ctrl_wr ? PWDATA[CTRL_RXIE] : rxie;
        // Setting takes priority over W1C; both cannot hit in one access anyway.
        txovf_d = (data_wr & tx_full) |
                  (txovf & ~(status_wr & PWDATA[ST_TXOVF]));
        rxunf_d = (data_rd & rx_empty) |
                  (rxunf & ~(status_wr & PWDATA[ST_RXUNF]));
        // IRQ is built from post-edge state so it tracks the cause one cycle later.
        irq_d = (txie_d & tx_empty_next) | (rxie_d & ~rx_empty_next) |
                txovf_d | rxunf_d;
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            en    <= 1'b0;
            txie  <= 1'b0;
            rxie  <= 1'b0;
            txovf <= 1'b0;
            rxunf <= 1'b0;
            irq_q <= 1'b0;
        end else begin
            en    <= en_d;
            txie  <= txie_d;
            rxie  <= rxie_d;
            txovf <= txovf_d;
            rxunf <= rxunf_d;
            irq_q <= irq_d;
        end
    end

    assign IRQ = irq_q;

    // ---------------- read mux ----------------
    always_comb begin
        status             = '0;
        status[ST_TXFULL]  = tx_full;
        status[ST_TXEMPTY] = tx_empty;
        status[ST_RXFULL]  = rx_full;
        status[ST_RXEMPTY] = rx_empty;
        status[ST_TXOVF]   = txovf;
        status[ST_RXUNF]   = rxunf;
    end

    always_comb begin
        rdata = '0;
        if (rd_acc) begin
            case (sel)
                REG_DATA:   rdata = rx_empty ? '0 : APB_DATA_W'(rx_head);
                REG_STATUS: rdata = APB_DATA_W'(status);
                REG_CTRL: begin
                    rdata[CTRL_EN]   = en;
                    rdata[CTRL_TXIE] = txie;
                    rdata[CTRL_RXIE] = rxie;
                end
                REG_COUNT: begin
                    rdata[COUNT_TX_LSB +: CW] = tx_count;
                    rdata[COUNT_RX_LSB +: CW] = rx_count;
                end
                default: rdata = '0;
            endcase
        end
    end

    assign PRDATA  = rdata;
    assign PREADY  = 1'b1;
    assign PSLVERR = access & ~addr_ok;

endmodule

// File: tb/tb_nanosoc_apb_usrt.sv
// tb/tb_nanosoc_apb_usrt.sv - self-checking bench for nanosoc_apb_usrt

module tb_nanosoc_apb_usrt;

    localparam int DEPTH = 4;

    logic        PCLK = 1'b0;
    logic        PRESETn;
    logic        PSEL, PENABLE, PWRITE;
    logic [11:0] PADDR;
    logic [31:0] PWDATA, PRDATA;
    logic        PREADY, PSLVERR;
    logic        TX_VALID, TX_READY, RX_VALID, RX_READY, IRQ;
    logic [7:0]  TX_DATA, RX_DATA;

    int n_cmp = 0;
    int n_bad = 0;
    int tx_pops = 0;
    logic [7:0] tx_q[$];
    logic [7:0] rx_q[$];

    typedef struct {
        bit          wr;
        logic [11:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        bit          exp_err;
    } vec_t;

    vec_t vt[10];

    nanosoc_apb_usrt #(.FIFO_DEPTH(DEPTH), .APB_ADDR_W(12), .APB_DATA_W(32)) dut (
        .PCLK(PCLK), .PRESETn(PRESETn), .PSEL(PSEL), .PENABLE(PENABLE),
        .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA),
        .PREADY(PREADY), .PSLVERR(PSLVERR), .TX_VALID(TX_VALID),
        .TX_DATA(TX_DATA), .TX_READY(TX_READY), .RX_VALID(RX_VALID),
        .RX_DATA(RX_DATA), .RX_READY(RX_READY), .IRQ(IRQ)
    );

    always #5 PCLK = ~PCLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Stream monitor: samples mid-low-phase, after all drivers have settled.
    always @(negedge PCLK) begin
        #2;
        if (PRESETn && TX_VALID && TX_READY) begin
            tx_pops++;
            if (tx_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL tx_unexpected: got 0x%0h expected no byte", TX_DATA);
            end else begin
                check("tx_byte", {24'b0, TX_DATA}, {24'b0, tx_q.pop_front()});
            end
        end
        if (PRESETn && RX_VALID && RX_READY) rx_q.push_back(RX_DATA);
    end

    task automatic apb(input bit wr, input logic [11:0] addr, input logic [31:0] wdata,
                       input bit rdy, output logic [31:0] rdata, output logic err);
        @(negedge PCLK);
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = addr; PWDATA = wdata;
        @(negedge PCLK);
        PENABLE = 1'b1;
        if (rdy) TX_READY = 1'b1;
        #1;
        rdata = PRDATA;
        err   = PSLVERR;
        // Reference model of the committed side effect (registered-full rule).
        if (wr && addr[11:4] == 8'h0) begin
            if (addr[3:2] == 2'd0 && tx_q.size() < DEPTH) tx_q.push_back(wdata[7:0]);
            if (addr[3:2] == 2'd2 && wdata[3]) begin
                tx_q.delete();
                rx_q.delete();
            end
        end
        @(negedge PCLK);
        PSEL = 1'b0; PENABLE = 1'b0;
        if (rdy) TX_READY = 1'b0;
    endtask

    task automatic wr(input logic [11:0] addr, input logic [31:0] wdata);
        logic [31:0] rd;
        logic        e;
        apb(1'b1, addr, wdata, 1'b0, rd, e);
    endtask

    task automatic rd_chk(input string name, input logic [11:0] addr, input logic [31:0] exp);
        logic [31:0] rd;
        logic        e;
        apb(1'b0, addr, 32'h0, 1'b0, rd, e);
        check(name, rd, exp);
        check({name, "_err"}, {31'b0, e}, 32'h0);
    endtask

    task automatic rd_data(input string name);
        logic [31:0] rd;
        logic        e;
        logic [31:0] exp;
        exp = (rx_q.size() == 0) ? 32'h0 : {24'b0, rx_q.pop_front()};
        apb(1'b0, 12'h000, 32'h0, 1'b0, rd, e);
        check(name, rd, exp);
    endtask

    initial begin
        logic [31:0] rd;
        logic        e;

        PRESETn = 1'b0; PSEL = 0; PENABLE = 0; PWRITE = 0; PADDR = '0; PWDATA = '0;
        TX_READY = 0; RX_VALID = 0; RX_DATA = '0;
        repeat (2) @(negedge PCLK);
        PRESETn = 1'b1;
        #1;
        check("rst_tx_valid", {31'b0, TX_VALID}, 0);
        check("rst_tx_data",  {24'b0, TX_DATA}, 0);
        check("rst_rx_ready", {31'b0, RX_READY}, 0);
        check("rst_irq",      {31'b0, IRQ}, 0);
        check("rst_pready",   {31'b0, PREADY}, 1);
        check("rst_prdata",   PRDATA, 0);
        check("rst_pslverr",  {31'b0, PSLVERR}, 0);

        // Decode table: illegal addresses, ignored COUNT write, reset register values.
        vt[0] = '{1'b1, 12'h010, 32'h55, 32'h0, 1'b1};
        vt[1] = '{1'b1, 12'h818, 32'h1,  32'h0, 1'b1};
        vt[2] = '{1'b0, 12'h010, 32'h0,  32'h0, 1'b1};
        vt[3] = '{1'b0, 12'h800, 32'h0,  32'h0, 1'b1};
        vt[4] = '{1'b1, 12'h00C, 32'hFFFF, 32'h0, 1'b0};
        vt[5] = '{1'b0, 12'h014, 32'h0,  32'h0, 1'b1};
        vt[6] = '{1'b0, 12'h004, 32'h0,  32'h0A, 1'b0};
        vt[7] = '{1'b0, 12'h00C, 32'h0,  32'h0, 1'b0};
        vt[8] = '{1'b0, 12'h008, 32'h0,  32'h0, 1'b0};
        vt[9] = '{1'b0, 12'h804, 32'h0,  32'h0, 1'b1};
        for (int i = 0; i < 10; i++) begin
            apb(vt[i].wr, vt[i].addr, vt[i].wdata, 1'b0, rd, e);
            check($sformatf("vec%0d_err", i), {31'b0, e}, {31'b0, vt[i].exp_err});
            if (!vt[i].wr) check($sformatf("vec%0d_rdata", i), rd, vt[i].exp_rdata);
        end
        check("decode_irq", {31'b0, IRQ}, 0);

        // TX fill with overflow, sink stalled.
        wr(12'h008, 32'h1);
        for (int i = 0; i < 5; i++) wr(12'h000, 32'h41 + i);
        check("tx_valid_fill", {31'b0, TX_VALID}, 1);
        check("tx_data_head",  {24'b0, TX_DATA}, 32'h41);
        check("ovf_irq",       {31'b0, IRQ}, 1);
        rd_chk("ovf_count",  12'h00C, 32'h4);
        rd_chk("ovf_status", 12'h004, 32'h19);

        // Drain: four bytes on four consecutive cycles.
        tx_pops  = 0;
        TX_READY = 1'b1;
        repeat (4) @(negedge PCLK);
        TX_READY = 1'b0;
        #2;
        check("drain_pops",  tx_pops, 4);
        check("drain_left",  tx_q.size(), 0);
        check("drain_valid", {31'b0, TX_VALID}, 0);

        // RX path with RXIE.
        wr(12'h004, 32'h10);
        wr(12'h008, 32'h5);
        check("rx_pre_irq",   {31'b0, IRQ}, 0);
        check("rx_pre_ready", {31'b0, RX_READY}, 1);
        RX_VALID = 1'b1;
        RX_DATA  = 8'h10;
        for (int i = 1; i < 4; i++) begin
            @(negedge PCLK);
            RX_DATA = 8'h10 + 8'(i);
            if (i == 1) begin
                #1;
                check("rx_irq_1cyc", {31'b0, IRQ}, 1);
            end
        end
        @(negedge PCLK);
        RX_VALID = 1'b0;
        #1;
        check("rx_full_ready", {31'b0, RX_READY}, 0);
        check("rx_model_cnt",  rx_q.size(), 4);
        for (int i = 0; i < 5; i++) rd_data($sformatf("rx_read%0d", i));
        rd_chk("unf_status", 12'h004, 32'h2A);
        check("unf_irq", {31'b0, IRQ}, 1);
        wr(12'h004, 32'h20);
        rd_chk("unf_clear", 12'h004, 32'h0A);
        check("unf_irq_clr", {31'b0, IRQ}, 0);

        // Simultaneous push and pop at occupancy 2.
        wr(12'h008, 32'h1);
        wr(12'h000, 32'h51);
        wr(12'h000, 32'h52);
        rd_chk("pp_count_pre", 12'h00C, 32'h2);
        apb(1'b1, 12'h000, 32'h53, 1'b1, rd, e);
        rd_chk("pp_count_post", 12'h00C, 32'h2);
        TX_READY = 1'b1;
        repeat (2) @(negedge PCLK);
        TX_READY = 1'b0;
        #2;
        check("pp_left",  tx_q.size(), 0);
        check("pp_valid", {31'b0, TX_VALID}, 0);

        // Flush with both FIFOs partly full.
        wr(12'h000, 32'h61);
        wr(12'h000, 32'h62);
        RX_VALID = 1'b1;
        RX_DATA  = 8'h71;
        @(negedge PCLK);
        RX_DATA = 8'h72;
        @(negedge PCLK);
        RX_VALID = 1'b0;
        rd_chk("fl_count_pre", 12'h00C, 32'h202);
        wr(12'h008, 32'h9);
        #1;
        check("fl_tx_valid", {31'b0, TX_VALID}, 0);
        rd_chk("fl_count", 12'h00C, 32'h0);
        rd_chk("fl_ctrl",  12'h008, 32'h1);
        rd_chk("fl_status", 12'h004, 32'h0A);

        // Asynchronous reset mid-stream.
        wr(12'h008, 32'h7);
        wr(12'h000, 32'h81);
        wr(12'h000, 32'h82);
        wr(12'h000, 32'h83);
        RX_VALID = 1'b1;
        RX_DATA  = 8'h99;
        @(negedge PCLK);
        TX_READY = 1'b1;
        @(negedge PCLK);
        #1;
        check("mid_irq",   {31'b0, IRQ}, 1);
        check("mid_valid", {31'b0, TX_VALID}, 1);
        #2;
        PRESETn = 1'b0;
        #1;
        check("ar_tx_valid", {31'b0, TX_VALID}, 0);
        check("ar_tx_data",  {24'b0, TX_DATA}, 0);
        check("ar_rx_ready", {31'b0, RX_READY}, 0);
        check("ar_irq",      {31'b0, IRQ}, 0);
        check("ar_prdata",   PRDATA, 0);
        check("ar_pready",   {31'b0, PREADY}, 1);
        tx_q.delete();
        rx_q.delete();
        TX_READY = 1'b0;
        RX_VALID = 1'b0;
        @(negedge PCLK);
        PRESETn = 1'b1;
        rd_chk("ar_ctrl",   12'h008, 32'h0);
        rd_chk("ar_status", 12'h004, 32'h0A);
        rd_chk("ar_count",  12'h00C, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
